// File: rtl/add_share_pkg.sv
// Shared constants and types for the shared-adder arbiter.
package add_share_pkg;

    // Default datapath width of the shared adder.
    localparam int ADD_W        = 32;
    // Default number of requesters and the matching index width.
    localparam int ADD_NREQ     = 3;
    localparam int ADD_REQ_ID_W = $clog2(ADD_NREQ);

    // Result register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage : add_share_pkg

// File: rtl/add_share_arb_add.sv
// Plain modulo-2^WIDTH adder shared by all requesters of add_share_arb.
module Add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // Carry out is intentionally discarded.
    assign sum = a + b;

endmodule : Add

// File: rtl/add_share_arb.sv
// Round-robin arbiter that sequences several requesters through one shared
// adder and holds the registered sum until the consumer accepts it.
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int WIDTH = ADD_W,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_sum,
    output logic [IDW-1:0]        resp_id
);

    // First set bit of valid, searching upward from ptr with wrap-around.
    // Each pointer value selects its own fixed rotation, so no arithmetic on
    // ptr is needed at run time.
    function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                                 input logic [IDW-1:0]  ptr);
        logic [NREQ-1:0] grant;
        logic            found;
        grant = '0;
        found = 1'b0;
        for (int p = 0; p < NREQ; p++) begin
            if (ptr == IDW'(p)) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && valid[(p + k) % NREQ]) begin
                        grant[(p + k) % NREQ] = 1'b1;
                        found                 = 1'b1;
                    end
                end
            end
        end
        return grant;
    endfunction

    // Index of the single set bit of a one-hot grant (0 when empty).
    function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = IDW'(i);
            end
        end
        return idx;
    endfunction

    // Successor of an index modulo NREQ, resolved as a constant lookup.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        logic [IDW-1:0] nxt;
        nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx == IDW'(i)) begin
                nxt = (i == NREQ - 1) ? IDW'(0) : IDW'(i + 1);
            end
        end
        return nxt;
    endfunction

    arb_state_t       state_r;
    arb_state_t       state_next_s;
    logic [IDW-1:0]   ptr_r;
    logic [WIDTH-1:0] sum_r;
    logic [IDW-1:0]   id_r;

    logic             can_accept_s;
    logic [NREQ-1:0]  grant_s;
    logic             transfer_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] b_sel_s;
    logic [WIDTH-1:0] add_sum_s;

    // Grant selection, operand steering and next-state decode.
    always_comb begin
        can_accept_s = (state_r == ST_EMPTY) || resp_ready;
        if (can_accept_s && rst_n) begin
            grant_s = rr_grant(req_valid, ptr_r);
        end else begin
            grant_s = '0;
        end
        transfer_s  = |grant_s;
        grant_idx_s = onehot_to_idx(grant_s);

        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                a_sel_s = req_a[i*WIDTH +: WIDTH];
                b_sel_s = req_b[i*WIDTH +: WIDTH];
            end else begin
                a_sel_s = a_sel_s;
                b_sel_s = b_sel_s;
            end
        end

        case (state_r)
            ST_EMPTY: begin
                state_next_s = transfer_s ? ST_FULL : ST_EMPTY;
            end
            ST_FULL: begin
                if (transfer_s) begin
                    state_next_s = ST_FULL;
                end else if (resp_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    Add #(.WIDTH(WIDTH)) u_add (
        .a   (a_sel_s),
        .b   (b_sel_s),
        .sum (add_sum_s)
    );

    // State, priority pointer and result register; result and pointer move only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            ptr_r   <= '0;
            sum_r   <= '0;
            id_r    <= '0;
        end else begin
            state_r <= state_next_s;
            if (transfer_s) begin
                ptr_r <= next_idx(grant_idx_s);
                sum_r <= add_sum_s;
                id_r  <= grant_idx_s;
            end else begin
                ptr_r <= ptr_r;
                sum_r <= sum_r;
                id_r  <= id_r;
            end
        end
    end

    assign req_ready  = grant_s;
    assign resp_valid = (state_r == ST_FULL);
    assign resp_sum   = sum_r;
    assign resp_id    = id_r;

endmodule : add_share_arb
